// File: rtl/ether_tx_sched.sv
// Two-requester round-robin payload scheduler: grants a frame, prefetches the first byte,
// then streams MSB-first dibits to the transmitter with zero padding, truncation and drain.
module ether_tx_sched #(
    parameter int unsigned MIN_BYTES = 46,
    parameter int unsigned MAX_BYTES = 1500
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [1:0] req_in,
    input  logic [7:0] byte0_in,
    input  logic [7:0] byte1_in,
    input  logic [1:0] byte_valid_in,
    input  logic [1:0] byte_last_in,
    output logic [1:0] byte_ready_out,
    input  logic       ready_in,
    input  logic       data_ready_in,
    output logic       trigger_out,
    output logic [1:0] data_out,
    output logic       last_dibit_out,
    output logic [1:0] grant_out,
    output logic       underrun_out,
    output logic       trunc_out
);
    localparam int unsigned CNT_W = 11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        STREAM   = 3'd2,
        DRAIN    = 3'd3,
        WAIT_TX  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               last_q, last_d;
    logic [7:0]         shift_q, shift_d;
    logic [1:0]         dibit_q, dibit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ended_q, ended_d;
    logic               loaded_q, loaded_d;
    logic               trigger_q, trigger_d;
    logic               underrun_q, underrun_d;
    logic               trunc_q, trunc_d;

    // Byte lane of the current owner
    logic       g_idx;
    logic [7:0] src_byte;
    logic       src_valid;
    logic       src_last;

    assign g_idx     = grant_q[1];
    assign src_byte  = g_idx ? byte1_in : byte0_in;
    assign src_valid = byte_valid_in[g_idx];
    assign src_last  = byte_last_in[g_idx];

    logic       in_pre, emit, first_emit, byte_end, final_c, cut_c, need_load, fetch, take;
    logic [7:0] load_byte;

    assign in_pre     = (state_q == PREFETCH);
    assign emit       = data_ready_in && (in_pre || (state_q == STREAM));
    // Transmitter wants the first dibit before any byte arrived
    assign first_emit = emit && in_pre && !loaded_q;
    assign byte_end   = emit && (state_q == STREAM) && (dibit_q == 2'd3);
    assign final_c    = byte_end && ended_q && (cnt_q >= CNT_W'(MIN_BYTES));
    assign cut_c      = byte_end && !ended_q && (cnt_q == CNT_W'(MAX_BYTES));
    assign need_load  = first_emit || (byte_end && !final_c && !cut_c);
    assign fetch      = need_load && !ended_q;
    assign take       = fetch && src_valid;
    assign load_byte  = take ? src_byte : 8'h00;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            last_q     <= 1'b1;
            shift_q    <= 8'h00;
            dibit_q    <= 2'd0;
            cnt_q      <= '0;
            ended_q    <= 1'b0;
            loaded_q   <= 1'b0;
            trigger_q  <= 1'b0;
            underrun_q <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            dibit_q    <= dibit_d;
            cnt_q      <= cnt_d;
            ended_q    <= ended_d;
            loaded_q   <= loaded_d;
            trigger_q  <= trigger_d;
            underrun_q <= underrun_d;
            trunc_q    <= trunc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        shift_d    = shift_q;
        dibit_d    = dibit_q;
        cnt_d      = cnt_q;
        ended_d    = ended_q;
        loaded_d   = loaded_q;
        trigger_d  = 1'b0;
        underrun_d = fetch && !src_valid;
        trunc_d    = cut_c;
        unique case (state_q)
            IDLE: begin
                if (ready_in && (req_in != 2'b00)) begin
                    // With both requesting, the one not granted last wins
                    grant_d   = (req_in == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req_in;
                    trigger_d = 1'b1;
                    shift_d   = 8'h00;
                    dibit_d   = 2'd0;
                    cnt_d     = '0;
                    ended_d   = 1'b0;
                    loaded_d  = 1'b0;
                    state_d   = PREFETCH;
                end
            end
            PREFETCH: begin
                if (first_emit) begin
                    shift_d  = {load_byte[5:0], 2'b00};
                    dibit_d  = 2'd1;
                    cnt_d    = CNT_W'(1);
                    ended_d  = take && src_last;
                    loaded_d = 1'b1;
                    state_d  = STREAM;
                end else if (data_ready_in) begin
                    shift_d  = {shift_q[5:0], 2'b00};
                    dibit_d  = 2'd1;
                    state_d  = STREAM;
                end else if (!loaded_q && src_valid) begin
                    shift_d  = src_byte;
                    cnt_d    = CNT_W'(1);
                    ended_d  = src_last;
                    loaded_d = 1'b1;
                end
            end
            STREAM: begin
                if (emit) begin
                    if (final_c) begin
                        state_d = WAIT_TX;
                    end else if (cut_c) begin
                        state_d = DRAIN;
                    end else if (byte_end) begin
                        shift_d = load_byte;
                        dibit_d = 2'd0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        ended_d = ended_q || (take && src_last);
                    end else begin
                        shift_d = {shift_q[5:0], 2'b00};
                        dibit_d = dibit_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                if (src_valid && src_last) state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (ready_in) begin
                    grant_d = 2'b00;
                    last_d  = g_idx;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_ready_out = 2'b00;
        data_out       = 2'b00;
        last_dibit_out = final_c || cut_c;
        if ((in_pre && !loaded_q) || ((state_q == STREAM) && fetch) || (state_q == DRAIN))
            byte_ready_out = grant_q;
        if (emit)
            data_out = first_emit ? load_byte[7:6] : shift_q[7:6];
    end

    assign trigger_out  = trigger_q;
    assign grant_out    = grant_q;
    assign underrun_out = underrun_q;
    assign trunc_out    = trunc_q;

endmodule

// File: tb/tb_ether_tx_sched.sv
// Directed bench for ether_tx_sched: a modelled requester and transmitter, with expected
// dibits queued per frame and popped on every data_ready cycle.
module tb_ether_tx_sched;
    localparam int MINB = 46;
    localparam int MAXB = 1500;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [1:0] req_in;
    logic [7:0] byte0_in, byte1_in;
    logic [1:0] byte_valid_in, byte_last_in, byte_ready_out;
    logic       ready_in, data_ready_in;
    logic       trigger_out, last_dibit_out, underrun_out, trunc_out;
    logic [1:0] data_out, grant_out;

    ether_tx_sched #(.MIN_BYTES(MINB), .MAX_BYTES(MAXB)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .req_in(req_in),
        .byte0_in(byte0_in), .byte1_in(byte1_in), .byte_valid_in(byte_valid_in),
        .byte_last_in(byte_last_in), .byte_ready_out(byte_ready_out),
        .ready_in(ready_in), .data_ready_in(data_ready_in), .trigger_out(trigger_out),
        .data_out(data_out), .last_dibit_out(last_dibit_out), .grant_out(grant_out),
        .underrun_out(underrun_out), .trunc_out(trunc_out)
    );

    always #5 clk_in = ~clk_in;

    int checks, errors;
    int src_idx, src_len, act_w, exp_total, dib_cnt, last_cnt, last_pos;
    int trig_cnt, un_cnt, tr_cnt, br_cnt, cyc_cnt;
    logic src_on, drop_on, dr_en, dr_alt, in_frame, ready_prev;
    logic [1:0] exp_q[$];
    logic [7:0] payload [0:1599];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic is_drop(input int i);
        return drop_on && (i == 5 || i == 6);
    endfunction

    task automatic drive_src();
        logic [7:0] b;
        logic v, l;
        b = 8'h00; v = 1'b0; l = 1'b0;
        if (src_on && src_idx < src_len) begin
            b = payload[src_idx];
            v = !is_drop(src_idx);
            l = (src_idx == src_len - 1);
        end
        byte0_in      = (act_w == 0) ? b : 8'h00;
        byte1_in      = (act_w == 1) ? b : 8'h00;
        byte_valid_in = (act_w == 1) ? {v, 1'b0} : {1'b0, v};
        byte_last_in  = (act_w == 1) ? {l, 1'b0} : {1'b0, l};
    endtask

    // One clock: drive at negedge, observe 1 ns later, then advance to next negedge
    task automatic cycle();
        logic [1:0] ag;
        logic [1:0] e;
        drive_src();
        data_ready_in = dr_en && (!dr_alt || cyc_cnt[0]);
        #1;
        ag = in_frame ? 2'(1 << act_w) : 2'b00;
        if (trigger_out) begin
            trig_cnt++;
            chk("trigger_needs_ready", int'(ready_prev), 1);
        end
        if (underrun_out) un_cnt++;
        if (trunc_out) tr_cnt++;
        if (byte_ready_out != 2'b00) br_cnt++;
        chk("ready_nongrant", int'(byte_ready_out & ~ag), 0);
        if (data_ready_in) begin
            if (exp_q.size() == 0) begin
                chk("extra_dibit", dib_cnt + 1, exp_total);
            end else begin
                e = exp_q.pop_front();
                dib_cnt++;
                chk("data", int'(data_out), int'(e));
                chk("last_dibit", int'(last_dibit_out), int'(dib_cnt == exp_total));
                if (last_dibit_out) begin
                    last_cnt++;
                    last_pos = dib_cnt;
                end
            end
        end else begin
            chk("data_gap", int'(data_out), 0);
            chk("last_gap", int'(last_dibit_out), 0);
        end
        if (src_on && src_idx < src_len && byte_ready_out[act_w[0]] &&
            (byte_valid_in[act_w[0]] || is_drop(src_idx)))
            src_idx++;
        ready_prev = ready_in;
        cyc_cnt++;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // mode: 0 incrementing bytes, 1 all 0xFF, 2 incrementing with bytes 5-6 withheld
    task automatic run_frame(input logic [1:0] req, input int w, input int n, input int mode,
                             input logic alt, input logic [1:0] next_req, input int abort_at);
        int nsent, bound;
        logic [7:0] b;
        act_w = w; src_len = n; src_idx = 0; drop_on = (mode == 2); dr_alt = alt;
        for (int k = 0; k < n; k++) payload[k] = (mode == 1) ? 8'hFF : 8'(k);
        nsent = (n > MAXB) ? MAXB : ((n < MINB) ? MINB : n);
        exp_q.delete();
        for (int k = 0; k < nsent; k++) begin
            b = (k < n && !is_drop(k)) ? payload[k] : 8'h00;
            for (int d = 0; d < 4; d++) exp_q.push_back(2'(b >> (6 - 2 * d)));
        end
        exp_total = nsent * 4; dib_cnt = 0; last_cnt = 0; last_pos = 0;
        trig_cnt = 0; un_cnt = 0; tr_cnt = 0; br_cnt = 0;
        src_on = 1'b1; in_frame = 1'b1; req_in = req; ready_in = 1'b1;
        bound = 50;
        while (trig_cnt == 0 && bound > 0) begin cycle(); bound--; end
        chk("trigger_seen", trig_cnt, 1);
        chk("grant", int'(grant_out), 1 << w);
        ready_in = 1'b0;
        repeat (4) cycle();
        dr_en = 1'b1;
        req_in = req ^ 2'b11;
        bound = exp_total * 2 + 50;
        while (exp_q.size() > 0 && bound > 0) begin
            cycle();
            bound--;
            if (abort_at > 0 && dib_cnt >= abort_at) return;
        end
        dr_en = 1'b0;
        chk("stream_done", exp_q.size(), 0);
        repeat (3) cycle();
        chk("grant_held", int'(grant_out), 1 << w);
        req_in = next_req; ready_in = 1'b1;
        bound = 400;
        while (grant_out != 2'b00 && bound > 0) begin cycle(); bound--; end
        chk("grant_clear", int'(grant_out), 0);
        chk("dibits", dib_cnt, exp_total);
        chk("last_pos", last_pos, exp_total);
        chk("last_cnt", last_cnt, 1);
        chk("triggers", trig_cnt, 1);
        chk("underruns", un_cnt, (mode == 2) ? 2 : 0);
        chk("truncs", tr_cnt, (n > MAXB) ? 1 : 0);
        chk("src_consumed", src_idx, n);
        if (mode == 1) chk("byte_ready_cnt", br_cnt, n);
        src_on = 1'b0; in_frame = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc_cnt = 0; act_w = 0; src_idx = 0; src_len = 0;
        exp_total = 0; dib_cnt = 0; trig_cnt = 0; un_cnt = 0; tr_cnt = 0; br_cnt = 0;
        last_cnt = 0; last_pos = 0;
        src_on = 1'b0; drop_on = 1'b0; dr_en = 1'b0; dr_alt = 1'b0; in_frame = 1'b0;
        ready_prev = 1'b0;
        req_in = 2'b11; ready_in = 1'b1; data_ready_in = 1'b1;
        byte0_in = 8'hA5; byte1_in = 8'h5A; byte_valid_in = 2'b11; byte_last_in = 2'b00;
        rst_n_in = 1'b0;
        #12;
        chk("rst_grant", int'(grant_out), 0);
        chk("rst_trigger", int'(trigger_out), 0);
        chk("rst_ready", int'(byte_ready_out), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_last", int'(last_dibit_out), 0);
        chk("rst_underrun", int'(underrun_out), 0);
        chk("rst_trunc", int'(trunc_out), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        req_in = 2'b00; data_ready_in = 1'b0;

        // Transmitter busy: requests must wait
        ready_in = 1'b0; req_in = 2'b11; trig_cnt = 0;
        repeat (5) cycle();
        chk("no_trigger_busy", trig_cnt, 0);

        // Round robin with both requesting
        run_frame(2'b11, 0, 46, 0, 1'b0, 2'b11, 0);
        run_frame(2'b11, 1, 46, 0, 1'b0, 2'b11, 0);
        run_frame(2'b11, 0, 46, 0, 1'b0, 2'b00, 0);

        run_frame(2'b01, 0, 60, 0, 1'b0, 2'b00, 0);
        run_frame(2'b01, 0, 10, 1, 1'b1, 2'b00, 0);
        run_frame(2'b01, 0, 60, 2, 1'b0, 2'b00, 0);
        run_frame(2'b01, 0, 1600, 0, 1'b0, 2'b01, 0);
        run_frame(2'b01, 0, 50, 0, 1'b0, 2'b00, 0);

        // Asynchronous reset in the middle of streaming
        run_frame(2'b01, 0, 60, 0, 1'b0, 2'b00, 100);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("mid_rst_grant", int'(grant_out), 0);
        chk("mid_rst_ready", int'(byte_ready_out), 0);
        chk("mid_rst_data", int'(data_out), 0);
        chk("mid_rst_last", int'(last_dibit_out), 0);
        chk("mid_rst_trigger", int'(trigger_out), 0);
        chk("mid_rst_underrun", int'(underrun_out), 0);
        chk("mid_rst_trunc", int'(trunc_out), 0);
        exp_q.delete();
        dr_en = 1'b0; src_on = 1'b0; in_frame = 1'b0; data_ready_in = 1'b0;
        req_in = 2'b10; ready_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        run_frame(2'b10, 1, 46, 0, 1'b0, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
